// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    // Fill bit for the divide-by-zero quotient (all ones at any width).
    localparam bit DZ_QUOT_FILL = 1'b1;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Combinational WIDTH+1-bit trial subtractor; nonneg is the carry-out (no borrow).
module div_trial_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           nonneg
);

    logic [WIDTH+1:0] sum;

    assign sum    = {1'b0, minuend} + {1'b0, ~subtrahend} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign diff   = sum[WIDTH:0];
    assign nonneg = sum[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Restoring integer divider: one quotient bit per clock, signed or unsigned operands.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] dvs_mag;
    logic             q_neg;
    logic             r_neg;

    logic signed [WIDTH-1:0] dvd_s;
    logic signed [WIDTH-1:0] dvs_s;
    logic                    dvd_neg_in;
    logic                    dvs_neg_in;
    logic                    dvs_zero;

    logic [WIDTH:0] shift;
    logic [WIDTH:0] trial_diff;
    logic [WIDTH:0] rem_nx;
    logic           trial_ok;
    logic           rem_nx_msb_unused;

    // Conditional two's-complement negate; also yields the magnitude of a negative operand.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign dvd_s      = $signed(dividend);
    assign dvs_s      = $signed(divisor);
    assign dvd_neg_in = is_signed && (dvd_s < 0);
    assign dvs_neg_in = is_signed && (dvs_s < 0);
    assign dvs_zero   = (divisor == '0);

    // The next dividend bit enters from the top of q_acc as quotient bits shift in below.
    assign shift = {rem_acc, q_acc[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .minuend    (shift),
        .subtrahend ({1'b0, dvs_mag}),
        .diff       (trial_diff),
        .nonneg     (trial_ok)
    );

    // A kept trial is always below the divisor, so its top bit is zero.
    assign rem_nx            = trial_ok ? trial_diff : shift;
    assign rem_nx_msb_unused = rem_nx[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = dvs_zero ? DONE : RUN;
            RUN:     if (cnt == CNT_ONE) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            q_acc       <= '0;
            rem_acc     <= '0;
            dvs_mag     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && dvs_zero) begin
                        quotient    <= {WIDTH{DZ_QUOT_FILL}};
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        q_acc   <= apply_sign(dividend, dvd_neg_in);
                        dvs_mag <= apply_sign(divisor, dvs_neg_in);
                        q_neg   <= dvd_neg_in ^ dvs_neg_in;
                        r_neg   <= dvd_neg_in;
                        rem_acc <= '0;
                        cnt     <= CNT_LOAD;
                    end
                end
                RUN: begin
                    rem_acc <= rem_nx[WIDTH-1:0];
                    q_acc   <= {q_acc[WIDTH-2:0], trial_ok};
                    cnt     <= cnt - CNT_ONE;
                end
                // MIN / -1 needs no special case: the magnitude quotient is already MIN.
                FIX: begin
                    quotient    <= apply_sign(q_acc, q_neg);
                    remainder   <= apply_sign(rem_acc, r_neg);
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
